// File: rtl/sram_rw_port_driver_pkg.sv
// rtl/sram_rw_port_driver_pkg.sv - shared widths, read latency and request record for the SRAM port driver
package sram_drv_pkg;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 16;
  localparam int MASK_W      = 8;
  localparam int SRAM_RD_LAT = 1;

  typedef struct packed {
    logic              wmode;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rw_port_driver_if.sv
// rtl/sram_rw_port_driver_if.sv - request/response channels plus the RW0 macro pins
interface sram_rw_port_driver_if #(
  parameter int ADDR_W = sram_drv_pkg::ADDR_W,
  parameter int DATA_W = sram_drv_pkg::DATA_W,
  parameter int MASK_W = sram_drv_pkg::MASK_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wmode;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  logic              RW0_clk;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  // master: requester plus the SRAM macro; slave: the port driver
  modport master (
    output req_valid, req_wmode, req_addr, req_wmask, req_wdata, resp_ready, RW0_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  RW0_clk, RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport slave (
    input  req_valid, req_wmode, req_addr, req_wmask, req_wdata, resp_ready, RW0_rdata,
    output req_ready, resp_valid, resp_rdata,
    output RW0_clk, RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

endinterface

// File: rtl/sram_rw_port_driver_resp_fifo.sv
// rtl/sram_rw_port_driver_resp_fifo.sv - in-order read-data buffer, any depth
module sram_resp_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  // explicit wrap keeps non-power-of-2 depths correct
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_rw_port_driver.sv
// rtl/sram_rw_port_driver.sv - registered RW0 issue stage, read-capture pipeline and credit-limited response buffer
module sram_rw_port_driver
  import sram_drv_pkg::*;
#(
  parameter int ADDR_W     = sram_drv_pkg::ADDR_W,
  parameter int DATA_W     = sram_drv_pkg::DATA_W,
  parameter int MASK_W     = sram_drv_pkg::MASK_W,
  parameter int RESP_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  sram_rw_port_driver_if.slave bus,
  output logic                 busy
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  sram_req_t              iss;
  logic                   iss_en;
  logic [SRAM_RD_LAT-1:0] rd_pipe;
  logic                   rd_pend;
  logic [CNT_W-1:0]       used;
  logic [CNT_W-1:0]       used_next;
  logic                   req_fire;
  logic                   rd_fire;
  logic                   resp_fire;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign req_fire  = bus.req_valid && bus.req_ready;
  assign rd_fire   = req_fire && !bus.req_wmode;
  assign resp_fire = bus.resp_valid && bus.resp_ready;

  // every accepted read owns a buffer slot until popped, so data can never be dropped
  assign bus.req_ready = (used < CNT_W'(RESP_DEPTH));
  assign busy          = (used != '0);

  always_comb begin
    used_next = used;
    case ({rd_fire, resp_fire})
      2'b10:   used_next = used + CNT_W'(1);
      2'b01:   used_next = used - CNT_W'(1);
      default: used_next = used;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iss     <= '0;
      iss_en  <= 1'b0;
      rd_pipe <= '0;
      used    <= '0;
    end else begin
      iss_en <= req_fire;
      if (req_fire) begin
        iss <= '{wmode: bus.req_wmode, addr: bus.req_addr,
                 wmask: bus.req_wmask, wdata: bus.req_wdata};
      end
      rd_pipe <= (rd_pipe << 1) | SRAM_RD_LAT'(iss_en && !iss.wmode);
      used    <= used_next;
    end
  end

  assign rd_pend = rd_pipe[SRAM_RD_LAT-1];

  assign bus.RW0_clk   = clock;
  assign bus.RW0_en    = iss_en;
  assign bus.RW0_wmode = iss.wmode;
  assign bus.RW0_addr  = ADDR_W'(iss.addr);
  assign bus.RW0_wmask = MASK_W'(iss.wmask);
  assign bus.RW0_wdata = DATA_W'(iss.wdata);

  sram_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend),
    .push_data (bus.RW0_rdata),
    .pop       (resp_fire),
    .head      (bus.resp_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.resp_valid = !fifo_empty;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(rd_pend && fifo_full && !resp_fire));

  a_credit_bound: assert property (@(posedge clock) disable iff (reset)
    fifo_count <= used);

endmodule

// File: doc/sram_rw_port_driver.md
Name: sram_rw_port_driver

Overview:
- Initiator for a single-port masked SRAM macro: depth 2048, width 16, 8 mask bits at 2-bit granularity, shared RW0 port, one-cycle read latency.
- Accepts read/write requests on a valid/ready channel and drives the macro's RW0 pins from registers.
- Captures read data on the correct cycle and returns it in order on a valid/ready response channel.
- Response backpressure is absorbed by a credit-limited response buffer, so read data is never lost.

Parameters:
- ADDR_W, 11, SRAM address width
- DATA_W, 16, SRAM data width
- MASK_W, 8, write-mask bits; each bit covers DATA_W/MASK_W data bits
- RESP_DEPTH, 2, response buffer entries (>=1); also the maximum number of outstanding reads

Ports:
- clock  in  1  block clock; also forwarded as RW0_clk
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_wmode  in  1  1=write, 0=read
- req_addr  in  ADDR_W  word address
- req_wmask  in  MASK_W  write mask; ignored for reads
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data valid
- resp_ready  in  1  consumer ready
- resp_rdata  out  DATA_W  read data
- RW0_clk  out  1  equals clock
- RW0_addr  out  ADDR_W  registered SRAM address
- RW0_en  out  1  registered SRAM enable
- RW0_wmode  out  1  registered write mode
- RW0_wmask  out  MASK_W  registered write mask
- RW0_wdata  out  DATA_W  registered write data
- RW0_rdata  in  DATA_W  SRAM read data
- busy  out  1  any read in flight or buffered

Behaviour:
- Reset (async, active-high) clears:
  - all RW0_* registers to 0, so RW0_en=0 immediately;
  - the credit counter and the response buffer;
  - the pending-read pipeline bit.
- Reset outputs: req_ready=1 (RESP_DEPTH>=1), resp_valid=0, busy=0, resp_rdata=0.
- Issue stage:
  - On a req handshake at cycle T, the RW0_* registers load the request, so RW0_en=1 during T+1 with addr/wmode/wmask/wdata.
  - With no handshake, RW0_en=0 the next cycle; other RW0 fields hold their previous values.
  - The macro never stalls, so one request issues per cycle at full throughput.
- Read pipeline:
  - rd_pend is set for cycle T+2 when the T+1 issue was a read.
  - In cycle T+2, RW0_rdata is pushed into the response buffer at the closing edge.
  - resp_valid is asserted from T+3. Read latency, accept to resp_valid, is 3 cycles.
- Credits:
  - used = reads accepted minus responses popped, with width clog2(RESP_DEPTH+1).
  - +1 on read handshake; -1 on resp handshake; unchanged when both occur in the same cycle.
  - req_ready = (used < RESP_DEPTH). It applies to writes too, and depends on neither req_valid nor req_wmode.
  - The buffer can therefore never overflow; a push into a full buffer is an assertion failure.
- Response buffer:
  - In-order FIFO with RESP_DEPTH entries; resp_rdata is driven from the head.
  - A push and a pop in the same cycle are both allowed when the buffer is non-empty.
  - Pointers wrap modulo RESP_DEPTH; occupancy is tracked by a separate counter, so RESP_DEPTH need not be a power of 2.
- Ordering: a write accepted after a read to the same address does not affect that read's data, since the read issues first. A read after a write returns the new data.
- Mask: only mask bit i is passed. The driver does no expansion; the macro applies data bits [i*G+G-1 : i*G], G=DATA_W/MASK_W.
- busy = (used != 0).
- Reset mid-operation: in-flight and buffered reads are discarded; no response is produced for them after reset.

Decomposition:
- Package sram_drv_pkg holds:
  - ADDR_W/DATA_W/MASK_W defaults;
  - the read latency constant SRAM_RD_LAT=1;
  - a request struct {wmode, addr, wmask, wdata}.
- One sub-module, sram_resp_fifo: a parameterised DATA_W x RESP_DEPTH synchronous FIFO with async reset, push/pop/count/full/empty.

Test Plan:
- Write then read: write addr 0x005, wmask 0xFF, wdata 0xBEEF; next cycle read 0x005 -> resp_rdata=0xBEEF, resp_valid 3 cycles after the read accept.
- Partial mask: preload 0x010=0x0000; write wmask 0x01, wdata 0xFFFF; read -> 0x0003. Then write wmask 0x80, wdata 0xFFFF; read -> 0xC003.
- Backpressure: resp_ready=0, issue reads to 0x001 and 0x002 -> req_ready drops after the 2nd accept and busy=1. Raise resp_ready -> 0x001 then 0x002 data in order; req_ready returns the cycle after the first pop.
- Streaming: resp_ready=1, back-to-back reads of 0x000..0x007 with RESP_DEPTH=4 -> one response per cycle in steady state, no data loss, order preserved.
- Simultaneous push/pop: a buffer holding 1 entry pops while a new read's data is pushed -> count stays at 1 and the data sequence is correct.
- Reset mid-flight: accept a read, assert reset during T+1 -> RW0_en falls asynchronously, resp_valid stays 0 after reset, busy=0, req_ready=1.
